// File: rtl/uart_rx_stream_driver_pkg.sv
// rtl/uart_rx_stream_driver_pkg.sv - shared constants, receiver states and clog2 helper
package uart_rx_stream_driver_pkg;

  localparam int BYTE_LEN = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK_WAIT
  } rx_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_stream_driver_sync_byte_fifo.sv
// rtl/uart_rx_stream_driver_sync_byte_fifo.sv - byte FIFO with registered read port
module sync_byte_fifo
  import uart_rx_stream_driver_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [BYTE_LEN-1:0] wdata,
  input  logic                pop,
  output logic [BYTE_LEN-1:0] rdata,
  output logic                full,
  output logic                empty
);
  localparam int AW = clog2(DEPTH);

  logic [BYTE_LEN-1:0] mem [DEPTH];
  logic [AW-1:0]       wptr;
  logic [AW-1:0]       rptr;
  logic [AW:0]         count;
  logic                do_push;
  logic                do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      rdata <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) begin
        rptr  <= rptr + 1'b1;
        rdata <= mem[rptr];
      end
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/uart_rx_stream_driver.sv
// rtl/uart_rx_stream_driver.sv - 8N1 UART receiver feeding a byte stream with error pulses
// Define UART_RX_PARITY_EN for 8E1 frames with parity_err reporting.
module uart_rx_stream_driver
  import uart_rx_stream_driver_pkg::*;
#(
  parameter int CYCLES_PER_BIT = 10,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rxd,
  input  logic                downstream_rdy,
  output logic [BYTE_LEN-1:0] out,
  output logic                outclk,
  output logic                frame_err,
  output logic                overflow,
  output logic                parity_err
);
  localparam int HALF = CYCLES_PER_BIT / 2;
  localparam int CW   = clog2(CYCLES_PER_BIT);

  rx_state_e           state;
  logic                rxd_m;
  logic                rxd_s;
  logic [CW-1:0]       low_cnt;
  logic [CW-1:0]       cyc_cnt;
  logic [3:0]          bit_cnt;
  logic [BYTE_LEN-1:0] shreg;
  logic                bit_centre;
  logic                stop_bad;
  logic                stop_good;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  assign stop_bad = par_bad;
`else
  assign stop_bad = 1'b0;
`endif

  // Synchronizer resets high so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  assign bit_centre = (cyc_cnt == CW'(CYCLES_PER_BIT - 1));
  assign stop_good  = (state == S_STOP) && bit_centre && rxd_s && !stop_bad;
  assign fifo_pop   = !fifo_empty && downstream_rdy;
  assign fifo_push  = stop_good && (!fifo_full || fifo_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      low_cnt    <= '0;
      cyc_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
      parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
`endif
    end else begin
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
      parity_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rxd_s) begin
            low_cnt <= '0;
          end else if (low_cnt == CW'(HALF - 1)) begin
            state   <= S_DATA;
            low_cnt <= '0;
            cyc_cnt <= '0;
            bit_cnt <= '0;
          end else begin
            low_cnt <= low_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_centre) begin
            cyc_cnt <= '0;
            shreg   <= {rxd_s, shreg[BYTE_LEN-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 4'(BYTE_LEN - 1)) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (bit_centre) begin
            cyc_cnt <= '0;
            par_bad <= (^shreg) ^ rxd_s;
            state   <= S_STOP;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (bit_centre) begin
            cyc_cnt <= '0;
            if (!rxd_s) begin
              frame_err <= 1'b1;
              state     <= S_BREAK_WAIT;
            end else begin
              state   <= S_IDLE;
              low_cnt <= '0;
              if (stop_bad)
                parity_err <= 1'b1;
              else if (fifo_full && !fifo_pop)
                overflow <= 1'b1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        S_BREAK_WAIT: begin
          if (rxd_s) begin
            state   <= S_IDLE;
            low_cnt <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) outclk <= 1'b0;
    else        outclk <= fifo_pop;
  end

  sync_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (shreg),
    .pop   (fifo_pop),
    .rdata (out),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_uart_rx_stream_driver.sv
// tb/tb_uart_rx_stream_driver.sv - directed frames checked against a frame-level receiver model
`timescale 1ns/1ps
module tb_uart_rx_stream_driver;
  localparam int CPB   = 10;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rxd = 1'b1;
  logic       downstream_rdy = 1'b1;
  logic [7:0] dout;
  logic       outclk;
  logic       frame_err;
  logic       overflow;
  logic       parity_err;

  uart_rx_stream_driver #(
    .CYCLES_PER_BIT(CPB),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rxd           (rxd),
    .downstream_rdy(downstream_rdy),
    .out           (dout),
    .outclk        (outclk),
    .frame_err     (frame_err),
    .overflow      (overflow),
    .parity_err    (parity_err)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int exp_fe = 0, exp_ov = 0, exp_pe = 0;
  int seen_fe = 0, seen_ov = 0, seen_pe = 0;
  int last_out_cyc = -1;
  int t_start;
  logic [7:0] exp_q[$];
  logic [7:0] got_log[$];
  logic [7:0] exp_head;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Every delivered byte must be the oldest byte the model expects.
  always @(negedge clk) begin
    if (frame_err)  seen_fe++;
    if (overflow)   seen_ov++;
    if (parity_err) seen_pe++;
    if (outclk) begin
      got_log.push_back(dout);
      last_out_cyc = cyc;
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_outclk: got 0x%02h required no byte", dout);
      end else begin
        exp_head = exp_q.pop_front();
        if (dout !== exp_head) begin
          mismatched++;
          $display("FAIL out_byte: got 0x%02h required 0x%02h", dout, exp_head);
        end
      end
    end
  end

  // Outcome of one frame, decided when its stop bit begins.
  task automatic model_frame(input logic [7:0] d, input logic stop_bit, input logic par_good);
    if (!stop_bit)                                   exp_fe++;
    else if (PARITY_ON && !par_good)                 exp_pe++;
    else if (!downstream_rdy && exp_q.size() >= DEPTH) exp_ov++;
    else                                             exp_q.push_back(d);
  endtask

  task automatic bit_time(input logic v);
    rxd = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input logic par_good, input logic aborted);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    if (PARITY_ON) bit_time(par_good ? ^d : ~^d);
    if (!aborted) model_frame(d, stop_bit, par_good);
    bit_time(stop_bit);
  endtask

  task automatic end_test(input string name);
    idle(20);
    check({name, "_frame_err_count"},  seen_fe, exp_fe);
    check({name, "_overflow_count"},   seen_ov, exp_ov);
    check({name, "_parity_err_count"}, seen_pe, exp_pe);
    check({name, "_undelivered"},      exp_q.size(), 0);
  endtask

  function automatic int last_byte(input int back);
    if (got_log.size() > back) return int'(got_log[got_log.size() - 1 - back]);
    return -1;
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_outclk",     outclk,     0);
    check("rst_out",        dout,       0);
    check("rst_frame_err",  frame_err,  0);
    check("rst_overflow",   overflow,   0);
    check("rst_parity_err", parity_err, 0);
    reset = 1'b1;
    idle(10);

    t_start = cyc;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    end_test("basic");
    check("basic_byte", last_byte(0), 8'hA5);
    check("basic_latency_in_window",
          int'((last_out_cyc - t_start) >= 97 + (PARITY_ON ? CPB : 0) &&
               (last_out_cyc - t_start) <= 101 + (PARITY_ON ? CPB : 0)), 1);

    rxd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(20);
    rxd = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(20);
    check("glitch_no_output", got_log.size(), 1);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    end_test("glitch");
    check("glitch_byte", last_byte(0), 8'h3C);

    send_frame(8'h00, 1'b0, 1'b1, 1'b0);
    repeat (50) @(posedge clk);
    #1;
    idle(20);
    check("break_single_frame_err", seen_fe, 1);
    send_frame(8'h81, 1'b1, 1'b1, 1'b0);
    end_test("break");
    check("break_byte", last_byte(0), 8'h81);

    downstream_rdy = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 1'b1, 1'b0);
      idle(5);
    end
    check("ovf_single_pulse", seen_ov, 1);
    downstream_rdy = 1'b1;
    end_test("ovf");
    for (int i = 0; i < 4; i++) check("ovf_order", last_byte(3 - i), i + 1);

    fork
      send_frame(8'hFF, 1'b1, 1'b1, 1'b1);
      begin
        repeat (55) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_outclk", outclk, 0);
        reset = 1'b1;
      end
    join
    idle(20);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    end_test("midreset");
    check("midreset_byte", last_byte(0), 8'h5A);

    if (PARITY_ON) begin
      send_frame(8'h07, 1'b1, 1'b1, 1'b0);
      idle(10);
      check("parity_good_byte", last_byte(0), 8'h07);
      send_frame(8'h07, 1'b1, 1'b0, 1'b0);
      end_test("parity");
      check("parity_err_single", seen_pe, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
